force_cache_write_scheduler: RTL and testbench
==============================================

Name: force_cache_write_scheduler

Overview:
- Sequential per-cell scheduler for the force-cache write port.
- Up to NUM_REQ PEs request a force read-modify-write (RMW) into one cell's force cache; the block grants at most one per cycle.
- Arbitration is round-robin. Requests whose particle address matches a write still in flight in the RMW pipeline are blocked (RAW hazard).
- A flush handshake drains the pipeline before motion update.

Parameters:
- NUM_REQ, 14, number of requesting PEs (home + 13 neighbours).
- PARTICLE_ID_WIDTH, 7, force-cache address width.
- RMW_LATENCY, 3, cycles from write enable until the cache entry is updated; range 1..8.
- SEL_WIDTH, $clog2(NUM_REQ), width of the grant index.

Ports:
- clk  input  1  single clock.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-PE request; held high until granted.
- req_addr  input  NUM_REQ*PARTICLE_ID_WIDTH  per-PE particle address; PE i occupies bits [i*PARTICLE_ID_WIDTH +: PARTICLE_ID_WIDTH].
- flush_req  input  1  level request to stop granting and drain.
- grant  output  NUM_REQ  one-hot write success back to the PEs; combinational, same cycle as the request.
- wr_enable  output  1  force cache write enable; equals |grant.
- wr_sel  output  SEL_WIDTH  index of the granted PE, used by the datapath mux; 0 when no grant.
- wr_addr  output  PARTICLE_ID_WIDTH  address of the granted PE; 0 when no grant.
- flush_done  output  1  pipeline empty and granting halted.

Behaviour:
- Reset (rst=0, asynchronous):
  - rr_ptr=0, hazard pipe cleared, state=RUN.
  - grant, wr_enable, wr_sel, wr_addr and flush_done are all 0 while rst=0.
- Eligibility: eligible[i] = req_valid[i] AND NOT (some valid pipe stage holds addr == req_addr[i]) AND state==RUN.
- Pick: the first eligible index scanning rr_ptr, rr_ptr+1, … with wrap modulo NUM_REQ.
- Grant has zero latency: grant, wr_enable, wr_sel and wr_addr are valid in the same cycle as the request.
- rr_ptr update on a clock edge:
  - after a grant to k, rr_ptr <= (k+1) mod NUM_REQ; when k=NUM_REQ-1 it wraps to 0;
  - with no grant, rr_ptr holds.
- Hazard pipe:
  - RMW_LATENCY stages of {valid, addr} form a shift register;
  - stage0 <= {wr_enable, wr_addr} each cycle, and stages shift every cycle;
  - an entry blocks its address for exactly RMW_LATENCY cycles after its grant cycle.
- Two requesters with the same address in the same cycle: only one is granted; the other is blocked next cycle by the hazard pipe.
- A request whose address matches an in-flight entry gets no grant even if it is the rr_ptr position. Arbitration skips it to the next eligible PE, so other addresses are not stalled (no head-of-line blocking).
- A requester that drops req_valid before being granted is legal and simply not considered.
- FSM:
  - RUN: normal granting. flush_req=1 moves to DRAIN on the next edge; the grant in that same cycle still occurs.
  - DRAIN: grant=0. When all pipe valid bits are 0, move to DONE.
  - DONE: flush_done=1, grant=0. flush_req=0 moves to RUN on the next edge. rr_ptr is preserved across a flush.
  - flush_req deasserting during DRAIN still completes DRAIN→DONE; flush_done then pulses for 1 cycle and the FSM returns to RUN.
- Reset mid-RMW discards pipe contents; the cache contents are not this block's concern.

Optional Feature:
- Macro: FORCE_WB_SCHED_STATS_EN.
- When defined:
  - adds output grant_count[31:0], incremented on each wr_enable;
  - adds output hazard_stall_count[31:0], incremented in each RUN cycle where some req_valid is high but no grant is made;
  - both counters saturate at 32'hFFFF_FFFF, reset to 0, and clear on the entry to RUN from DONE.
- When not defined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package force_wb_pkg holds:
  - localparams NUM_REQ_DEFAULT=14 and PARTICLE_ID_WIDTH_DEFAULT=7;
  - the FSM state encoding (RUN=2'd0, DRAIN=2'd1, DONE=2'd2);
  - a typedef for the hazard entry {valid, addr}.
- One sub-module, rr_priority_picker: combinational rotate/priority-encode/un-rotate, taking the eligible vector and rr_ptr and producing one-hot grant plus index.

Test Plan:
- Requests 14'h3FFF with distinct addrs 0..13 held, rr_ptr=0 → grants go to PE0,1,…,13 on consecutive cycles, then wrap to 0; wr_addr follows the PE's addr.
- PE2 and PE5 both request addr 7'h10 → PE2 is granted in cycle t; PE5 is blocked in t..t+3 and granted in t+4 (RMW_LATENCY=3).
- PE0 at addr 5 is granted; next cycle PE0 requests addr 5 again and PE1 requests addr 9 → PE1 is granted immediately; PE0 waits 3 cycles.
- flush_req raised with 2 writes in flight → no grants from the next cycle; flush_done=1 after the pipe drains (≤3 cycles); flush_req low → RUN resumes with rr_ptr preserved.
- Assert rst=0 asynchronously mid-stream with wr_enable=1 → outputs go to 0 without waiting for clk; after release the first grant goes to the lowest-indexed requester.
- With FORCE_WB_SCHED_STATS_EN and 10 grants plus 4 hazard-only cycles → grant_count=10 and hazard_stall_count=4.

Source files
------------

// File: rtl/force_wb_pkg.sv
// Shared definitions for the force-cache write scheduler.
//   NUM_REQ_DEFAULT / PARTICLE_ID_WIDTH_DEFAULT : default geometry (home + 13 neighbours)
//   wb_state_t     : scheduler FSM encoding
//   hazard_entry_t : one in-flight RMW slot {valid, addr} at default width
package force_wb_pkg;
    localparam int NUM_REQ_DEFAULT           = 14;
    localparam int PARTICLE_ID_WIDTH_DEFAULT = 7;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } wb_state_t;

    typedef struct packed {
        logic                                 valid;
        logic [PARTICLE_ID_WIDTH_DEFAULT-1:0] addr;
    } hazard_entry_t;
endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: rotate the eligible vector so i_ptr sits at bit 0,
// take the lowest set bit, then un-rotate back to a PE index.
//   i_elig  : eligible requesters
//   i_ptr   : round-robin start position (< NUM_REQ)
//   o_grant : one-hot grant, 0 when nothing eligible
//   o_idx   : granted index, 0 when nothing eligible
//   o_any   : some requester granted
module rr_priority_picker #(
    parameter int NUM_REQ   = 14,
    parameter int SEL_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   i_elig,
    input  logic [SEL_WIDTH-1:0] i_ptr,
    output logic [NUM_REQ-1:0]   o_grant,
    output logic [SEL_WIDTH-1:0] o_idx,
    output logic                 o_any
);
    localparam logic [SEL_WIDTH:0] LP_N = (SEL_WIDTH+1)'(NUM_REQ);

    logic [NUM_REQ-1:0] w_rot;
    logic [SEL_WIDTH:0] w_k;
    logic [SEL_WIDTH-1:0] w_off;
    logic [SEL_WIDTH:0] w_sum;

    always_comb begin
        w_rot = '0;
        w_k   = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_k = {1'b0, i_ptr} + (SEL_WIDTH+1)'(j);
            if (w_k >= LP_N) w_k = w_k - LP_N;
            w_rot[j] = i_elig[w_k[SEL_WIDTH-1:0]];
        end

        // downward scan leaves the lowest set offset
        w_off = '0;
        o_any = 1'b0;
        for (int j = NUM_REQ-1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = SEL_WIDTH'(j);
                o_any = 1'b1;
            end
        end

        w_sum = {1'b0, i_ptr} + {1'b0, w_off};
        if (w_sum >= LP_N) w_sum = w_sum - LP_N;
        o_idx   = o_any ? w_sum[SEL_WIDTH-1:0] : '0;
        o_grant = '0;
        if (o_any) o_grant[o_idx] = 1'b1;
    end
endmodule

// File: rtl/force_cache_write_scheduler.sv
// Per-cell force-cache write-port scheduler: round-robin grant of one RMW per
// cycle among NUM_REQ PEs, blocking addresses still in the RMW pipeline, with
// a flush handshake that stops granting and drains the pipeline.
// Optional macro FORCE_WB_SCHED_STATS_EN adds grant/hazard-stall counters.
//   clk, rst          : clock, asynchronous active-low reset
//   req_valid/addr    : per-PE request and particle address (PE i at i*W +: W)
//   flush_req         : level request to halt and drain
//   grant             : one-hot, combinational, same cycle as request
//   wr_enable/sel/addr: cache write strobe, granted index, granted address
//   flush_done        : pipeline empty and granting halted
//   grant_count, hazard_stall_count : saturating stats (macro only)
module force_cache_write_scheduler
    import force_wb_pkg::*;
#(
    parameter int NUM_REQ           = NUM_REQ_DEFAULT,
    parameter int PARTICLE_ID_WIDTH = PARTICLE_ID_WIDTH_DEFAULT,
    parameter int RMW_LATENCY       = 3,
    parameter int SEL_WIDTH         = $clog2(NUM_REQ)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ*PARTICLE_ID_WIDTH-1:0] req_addr,
    input  logic                                 flush_req,
    output logic [NUM_REQ-1:0]                   grant,
    output logic                                 wr_enable,
    output logic [SEL_WIDTH-1:0]                 wr_sel,
    output logic [PARTICLE_ID_WIDTH-1:0]         wr_addr,
    output logic                                 flush_done
`ifdef FORCE_WB_SCHED_STATS_EN
   ,output logic [31:0]                          grant_count,
    output logic [31:0]                          hazard_stall_count
`endif
);
    wb_state_t r_state, w_state_nxt;
    logic [SEL_WIDTH-1:0]         r_rr_ptr;
    logic [RMW_LATENCY-1:0]       r_pipe_vld;
    logic [PARTICLE_ID_WIDTH-1:0] r_pipe_addr [RMW_LATENCY];

    logic [PARTICLE_ID_WIDTH-1:0] w_addr [NUM_REQ];
    logic [NUM_REQ-1:0]           w_hit, w_elig, w_grant;
    logic [SEL_WIDTH-1:0]         w_sel;
    logic                         w_any, w_run;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr
        assign w_addr[gi] = req_addr[gi*PARTICLE_ID_WIDTH +: PARTICLE_ID_WIDTH];
    end

    // RAW hazard: any live pipe slot holding the same address blocks the PE
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < NUM_REQ; i++)
            for (int s = 0; s < RMW_LATENCY; s++)
                if (r_pipe_vld[s] && (r_pipe_addr[s] == w_addr[i])) w_hit[i] = 1'b1;
    end

    // rst gates eligibility so the combinational grant path is quiet in reset
    assign w_elig = req_valid & ~w_hit & {NUM_REQ{w_run & rst}};

    rr_priority_picker #(
        .NUM_REQ   (NUM_REQ),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_pick (
        .i_elig  (w_elig),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_sel),
        .o_any   (w_any)
    );

    assign grant     = w_grant;
    assign wr_enable = w_any;
    assign wr_sel    = w_sel;
    assign wr_addr   = w_any ? w_addr[w_sel] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= RUN;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run       = 1'b0;
        flush_done  = 1'b0;
        case (r_state)
            RUN: begin
                w_run = 1'b1;
                if (flush_req) w_state_nxt = DRAIN;
            end
            DRAIN: if (~|r_pipe_vld) w_state_nxt = DONE;
            DONE: begin
                flush_done = 1'b1;
                if (!flush_req) w_state_nxt = RUN;
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr   <= '0;
            r_pipe_vld <= '0;
            for (int s = 0; s < RMW_LATENCY; s++) r_pipe_addr[s] <= '0;
        end else begin
            if (w_any) r_rr_ptr <= (w_sel == SEL_WIDTH'(NUM_REQ-1)) ? '0 : w_sel + 1'b1;
            r_pipe_vld[0]  <= w_any;
            r_pipe_addr[0] <= wr_addr;
            for (int s = 1; s < RMW_LATENCY; s++) begin
                r_pipe_vld[s]  <= r_pipe_vld[s-1];
                r_pipe_addr[s] <= r_pipe_addr[s-1];
            end
        end
    end

`ifdef FORCE_WB_SCHED_STATS_EN
    logic [31:0] r_grant_count, r_stall_count;
    logic        w_clr, w_stall;

    assign w_clr   = (r_state == DONE) && (w_state_nxt == RUN);
    assign w_stall = w_run & (|req_valid) & ~w_any;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_grant_count <= '0;
            r_stall_count <= '0;
        end else if (w_clr) begin
            r_grant_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_any && (r_grant_count != '1))   r_grant_count <= r_grant_count + 32'd1;
            if (w_stall && (r_stall_count != '1)) r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign grant_count        = r_grant_count;
    assign hazard_stall_count = r_stall_count;
`endif
endmodule

// File: tb/tb_force_cache_write_scheduler.sv
// Directed bench for force_cache_write_scheduler (default geometry, RMW_LATENCY=3).
// Inputs change 1ns after posedge; outputs are sampled on the negedge.
module tb_force_cache_write_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] req_valid;
    logic [97:0] req_addr;
    logic        flush_req;
    logic [13:0] grant;
    logic        wr_enable;
    logic [3:0]  wr_sel;
    logic [6:0]  wr_addr;
    logic        flush_done;
`ifdef FORCE_WB_SCHED_STATS_EN
    logic [31:0] grant_count, hazard_stall_count;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    force_cache_write_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .flush_req  (flush_req),
        .grant      (grant),
        .wr_enable  (wr_enable),
        .wr_sel     (wr_sel),
        .wr_addr    (wr_addr),
        .flush_done (flush_done)
`ifdef FORCE_WB_SCHED_STATS_EN
       ,.grant_count        (grant_count),
        .hazard_stall_count (hazard_stall_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input int i, input logic [6:0] a);
        req_addr[i*7 +: 7] = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_grant(input string tag, input int pe, input logic [6:0] a);
        chk({tag, ".grant"}, 32'(grant), 32'(1) << pe);
        chk({tag, ".wr_en"}, 32'(wr_enable), 32'd1);
        chk({tag, ".sel"},   32'(wr_sel), 32'(pe));
        chk({tag, ".addr"},  32'(wr_addr), 32'(a));
    endtask

    task automatic exp_none(input string tag);
        chk({tag, ".grant"}, 32'(grant), 32'd0);
        chk({tag, ".wr_en"}, 32'(wr_enable), 32'd0);
        chk({tag, ".sel"},   32'(wr_sel), 32'd0);
        chk({tag, ".addr"},  32'(wr_addr), 32'd0);
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        repeat (n) begin
            @(negedge clk);
            exp_none("idle");
            tick();
        end
    endtask

    initial begin
        rst = 1'b0; req_valid = '0; req_addr = '0; flush_req = 1'b0;
        #2;
        // reset holds outputs low even with every PE requesting
        req_valid = '1;
        for (int i = 0; i < 14; i++) set_addr(i, 7'(i));
        #1;
        exp_none("rst_hold");
        chk("rst_flush_done", 32'(flush_done), 32'd0);
        tick(); tick();
        rst = 1'b1;

        // full round robin with distinct addresses, wraps after PE13
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            exp_grant($sformatf("rr%0d", c), c % 14, 7'(c % 14));
            tick();
        end
        idle(4);                       // rr_ptr = 2

        // same address from PE2 and PE5
        req_valid = 14'h0024;
        set_addr(2, 7'h10); set_addr(5, 7'h10);
        @(negedge clk); exp_grant("same_t", 2, 7'h10);
        tick();
        req_valid[2] = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk); exp_none($sformatf("same_blk%0d", k));
            tick();
        end
        @(negedge clk); exp_grant("same_t4", 5, 7'h10);
        tick();
        idle(4);                       // rr_ptr = 6

        // no head-of-line blocking
        req_valid = 14'h0001; set_addr(0, 7'h05);
        @(negedge clk); exp_grant("hol_pe0", 0, 7'h05);
        tick();
        req_valid = 14'h0003; set_addr(1, 7'h09);
        @(negedge clk); exp_grant("hol_pe1", 1, 7'h09);
        tick();
        req_valid = 14'h0001;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); exp_none($sformatf("hol_wait%0d", k));
            tick();
        end
        @(negedge clk); exp_grant("hol_pe0_again", 0, 7'h05);
        tick();
        idle(4);                       // rr_ptr = 1

        // flush with two writes in flight
        req_valid = 14'h000E;
        set_addr(1, 7'h20); set_addr(2, 7'h21); set_addr(3, 7'h22);
        @(negedge clk); exp_grant("fl_a", 1, 7'h20);
        tick();
        req_valid[1] = 1'b0; flush_req = 1'b1;
        @(negedge clk); exp_grant("fl_same_cycle", 2, 7'h21);
        tick();
        for (int d = 0; d < 4; d++) begin
            @(negedge clk);
            exp_none($sformatf("fl_drain%0d", d));
            chk($sformatf("fl_drain_done%0d", d), 32'(flush_done), 32'd0);
            tick();
        end
        @(negedge clk);
        chk("fl_done", 32'(flush_done), 32'd1);
        exp_none("fl_done_nogrant");
        flush_req = 1'b0;
        req_valid[0] = 1'b1; set_addr(0, 7'h30);
        tick();
        @(negedge clk);
        exp_grant("fl_resume_ptr", 3, 7'h22);  // rr_ptr preserved at 3
        chk("fl_resume_done", 32'(flush_done), 32'd0);
        tick();
        req_valid[3] = 1'b0;
        @(negedge clk); exp_grant("fl_resume_pe0", 0, 7'h30);
        tick();
        idle(4);                       // rr_ptr = 1

        // asynchronous reset mid-stream
        req_valid = 14'h00A0;
        set_addr(5, 7'h40); set_addr(7, 7'h41);
        @(negedge clk); exp_grant("ar_pe5", 5, 7'h40);
        tick();
        @(negedge clk); exp_grant("ar_pe7", 7, 7'h41);
        #2 rst = 1'b0;
        #1;
        exp_none("ar_async");
        chk("ar_flush_done", 32'(flush_done), 32'd0);
        tick(); tick();
        rst = 1'b1;
        @(negedge clk); exp_grant("ar_first", 5, 7'h40);   // ptr 0, pipe cleared
        tick();

        // mix of grants and hazard-only cycles (10 grants, 4 stalls since reset)
        req_valid = 14'h0080;
        @(negedge clk); exp_grant("st_pe7", 7, 7'h41);
        tick();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); exp_none($sformatf("st_blk%0d", k));
            tick();
        end
        @(negedge clk); exp_grant("st_pe7_again", 7, 7'h41);
        tick();
        @(negedge clk); exp_none("st_blk3");
        tick();
        req_valid = 14'h007F;
        for (int i = 0; i < 7; i++) set_addr(i, 7'h50 + 7'(i));
        for (int j = 0; j < 7; j++) begin
            @(negedge clk); exp_grant($sformatf("st_g%0d", j), j, 7'h50 + 7'(j));
            tick();
        end
        req_valid = '0;
        @(negedge clk); exp_none("st_end");
        tick();
`ifdef FORCE_WB_SCHED_STATS_EN
        @(negedge clk);
        chk("grant_count", grant_count, 32'd10);
        chk("hazard_stall_count", hazard_stall_count, 32'd4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
